pcie_cfg_snapshot: RTL

PCIE_CFG_SNAPSHOT -- requirements
Module: pcie_cfg_snapshot

---
 rtl/pcie_cfg_snapshot_if.sv | 29 ++
 rtl/pcie_cfg_snapshot.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pcie_cfg_snapshot_if.sv
// Bundles the monitored cfg_mgmt bus and the host snapshot read port.
// The master side drives cfg_mgmt and host strobes; the snapshot block is the slave.
interface pcie_cfg_snapshot_if;
  logic [9:0]  cfg_mgmt_addr;
  logic        cfg_mgmt_read;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic        snap_clear;
  logic        snap_rd_en;
  logic [5:0]  snap_rd_addr;
  logic [31:0] snap_rd_data;
  logic        snap_rd_valid;
  logic        snap_rd_hit;
  logic        snap_full;
  logic [31:0] snap2ctr_status;

  modport master (
    output cfg_mgmt_addr, cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_read_data,
           cfg_mgmt_read_write_done, snap_clear, snap_rd_en, snap_rd_addr,
    input  snap_rd_data, snap_rd_valid, snap_rd_hit, snap_full, snap2ctr_status
  );

  modport slave (
    input  cfg_mgmt_addr, cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_read_data,
           cfg_mgmt_read_write_done, snap_clear, snap_rd_en, snap_rd_addr,
    output snap_rd_data, snap_rd_valid, snap_rd_hit, snap_full, snap2ctr_status
  );
endinterface

// File: rtl/pcie_cfg_snapshot.sv
// Passive cfg_mgmt monitor: captures completed config reads (dwords 0..63)
// into a snapshot RAM and keeps access statistics and sticky error flags.
module pcie_cfg_snapshot #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
  parameter logic [5:0] LAST_ADDR      = 6'h28
) (
  input logic            user_clk,
  input logic            user_reset,
  pcie_cfg_snapshot_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_RD = 2'd1,
    PEND_WR = 2'd2
  } state_t;

  state_t      state_reg;
  logic [7:0]  tmo_cnt_reg;
  logic [9:0]  addr_reg;
  logic [63:0] valid_reg;
  logic [63:0] valid_next;
  logic [15:0] capture_count_reg;
  logic [3:0]  timeout_count_reg;
  logic        overlap_err_reg;
  logic        spurious_done_reg;
  logic        out_of_range_reg;
  logic        rw_conflict_reg;
  logic [5:0]  last_addr_reg;
  logic        snap_full_reg;
  logic        rd_valid_reg;
  logic        rd_hit_reg;
  logic [31:0] rd_q_reg;
  logic        capture_en;
  logic [31:0] mem [64];

  // A capture racing snap_clear is dropped so the cleared snapshot stays empty.
  always_comb begin
    capture_en = (state_reg == PEND_RD) && bus.cfg_mgmt_read_write_done &&
                 (addr_reg[9:6] == 4'd0) && !bus.snap_clear;
    valid_next = valid_reg;
    if (bus.snap_clear)
      valid_next = '0;
    else if (capture_en)
      valid_next[addr_reg[5:0]] = 1'b1;
  end

  // Snapshot RAM: no reset, registered read-first port.
  always_ff @(posedge user_clk) begin
    if (capture_en)
      mem[addr_reg[5:0]] <= bus.cfg_mgmt_read_data;
    if (bus.snap_rd_en)
      rd_q_reg <= mem[bus.snap_rd_addr];
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_reg         <= IDLE;
      tmo_cnt_reg       <= '0;
      addr_reg          <= '0;
      valid_reg         <= '0;
      capture_count_reg <= '0;
      timeout_count_reg <= '0;
      overlap_err_reg   <= 1'b0;
      spurious_done_reg <= 1'b0;
      out_of_range_reg  <= 1'b0;
      rw_conflict_reg   <= 1'b0;
      last_addr_reg     <= '0;
      snap_full_reg     <= 1'b0;
      rd_valid_reg      <= 1'b0;
      rd_hit_reg        <= 1'b0;
    end else begin
      valid_reg     <= valid_next;
      snap_full_reg <= &valid_next[LAST_ADDR:0];
      rd_valid_reg  <= bus.snap_rd_en;
      if (bus.snap_rd_en)
        rd_hit_reg <= valid_reg[bus.snap_rd_addr];

      case (state_reg)
        IDLE: begin
          if (bus.cfg_mgmt_read && bus.cfg_mgmt_write) begin
            rw_conflict_reg <= 1'b1;
          end else if (bus.cfg_mgmt_read) begin
            addr_reg    <= bus.cfg_mgmt_addr;
            tmo_cnt_reg <= '0;
            state_reg   <= PEND_RD;
          end else if (bus.cfg_mgmt_write) begin
            tmo_cnt_reg <= '0;
            state_reg   <= PEND_WR;
          end
          if (bus.cfg_mgmt_read_write_done)
            spurious_done_reg <= 1'b1;
        end
        PEND_RD, PEND_WR: begin
          if (bus.cfg_mgmt_read || bus.cfg_mgmt_write)
            overlap_err_reg <= 1'b1;
          // Completion wins over a timeout landing in the same cycle.
          if (bus.cfg_mgmt_read_write_done) begin
            state_reg <= IDLE;
            if (state_reg == PEND_RD) begin
              if (addr_reg[9:6] != 4'd0) begin
                out_of_range_reg <= 1'b1;
              end else if (capture_en) begin
                last_addr_reg <= addr_reg[5:0];
                if (capture_count_reg != 16'hFFFF)
                  capture_count_reg <= capture_count_reg + 16'd1;
              end
            end
          end else if (tmo_cnt_reg == TIMEOUT_CYCLES) begin
            state_reg <= IDLE;
            if (timeout_count_reg != 4'hF)
              timeout_count_reg <= timeout_count_reg + 4'd1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Clear overrides any statistic update from this cycle but leaves the FSM alone.
      if (bus.snap_clear) begin
        capture_count_reg <= '0;
        timeout_count_reg <= '0;
        overlap_err_reg   <= 1'b0;
        spurious_done_reg <= 1'b0;
        out_of_range_reg  <= 1'b0;
        rw_conflict_reg   <= 1'b0;
        last_addr_reg     <= '0;
      end
    end
  end

  assign bus.snap_rd_data    = rd_hit_reg ? rd_q_reg : 32'd0;
  assign bus.snap_rd_valid   = rd_valid_reg;
  assign bus.snap_rd_hit     = rd_hit_reg;
  assign bus.snap_full       = snap_full_reg;
  assign bus.snap2ctr_status = {capture_count_reg, timeout_count_reg, overlap_err_reg,
                                spurious_done_reg, out_of_range_reg, rw_conflict_reg,
                                last_addr_reg, state_reg};

endmodule
